uart_tx_queue: RTL
==================

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, log2(DEPTH).
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 16, clocks to wait for txBusy to assert after a transmit pulse.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port wrData, input, 8 bits: byte to enqueue.
REQ-007 SHALL have port wrEn, input, 1 bit: enqueue strobe, sampled each clock.
REQ-008 SHALL have port clrOverflow, input, 1 bit: clears the overflow flag.
REQ-009 SHALL have port txBusy, input, 1 bit: high while the UART transmitter is shifting a frame.
REQ-010 SHALL have port dataIn, output, 8 bits: byte presented to the UART transmitter.
REQ-011 SHALL have port transmit, output, 1 bit: one-clock start pulse to the transmitter.
REQ-012 SHALL have port full, output, 1 bit: FIFO holds DEPTH entries.
REQ-013 SHALL have port empty, output, 1 bit: FIFO holds 0 entries.
REQ-014 SHALL have port count, output, ADDR_WIDTH+1 bits: current occupancy, 0..DEPTH.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag set on a dropped write.

Function
REQ-016 SHALL implement the FIFO as a circular buffer with ADDR_WIDTH-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-017 SHALL accept a write (store wrData, advance the write pointer, count+1) when wrEn=1 and full=0.
REQ-018 SHALL reject a write when wrEn=1 and full=1, even if a pop occurs the same clock; the byte is lost and overflow is set.
REQ-019 SHALL update full, empty and count as registered values that agree with occupancy after every edge.
REQ-020 SHALL leave count unchanged, with both pointers advancing, on a simultaneous accepted write and pop.
REQ-021 SHALL clear overflow on clrOverflow=1; if clrOverflow and a dropped write occur in the same clock, overflow SHALL end that clock set.
REQ-022 SHALL sequence with an FSM of states IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-023 SHALL, in IDLE with empty=0 and txBusy=0, pop the head entry, register it into dataIn, and go to START; otherwise it SHALL stay in IDLE.
REQ-024 SHALL, in START, drive transmit=1 for exactly this one clock and go to WAIT_BUSY.
REQ-025 SHALL, in WAIT_BUSY, go to WAIT_DONE when txBusy=1, or go to IDLE after BUSY_TIMEOUT clocks without txBusy (the byte counts as sent).
REQ-026 SHALL, in WAIT_DONE, go to IDLE on the clock where txBusy=0.
REQ-027 SHALL keep dataIn stable from the pop until the next pop.
REQ-028 SHALL drive transmit=0 in every state except START.
REQ-029 SHALL achieve this latency: with the FIFO empty, state IDLE and txBusy=0, a write at edge N gives count=1 after N; the pop at edge N+1 gives dataIn valid and transmit=1 from N+1 to N+2.
REQ-030 SHALL not pop while empty=1; the FSM waits in IDLE.

Reset
REQ-031 SHALL, on reset=1 at any time (including mid-frame), asynchronously force the FSM to IDLE, both pointers to 0, count=0, empty=1, full=0, overflow=0, transmit=0 and dataIn=8'h00.
REQ-032 SHALL not clear the FIFO storage array on reset; its contents are don't-care.
REQ-033 SHALL not pop, write or assert transmit on the first rising edge after reset deasserts.

Verification
REQ-034 SHALL be verified by single byte: write 8'hBE into empty FIFO, txBusy low -> dataIn=8'hBE, transmit high one clock, one clock after write edge; count returns to 0.
REQ-035 SHALL be verified by handshake: txBusy raised 2 clocks after transmit and held 500 clocks, second byte 8'h5A queued -> no second transmit until 1 clock after txBusy falls; then dataIn=8'h5A.
REQ-036 SHALL be verified by full and overflow: hold txBusy=1, write 17 bytes 8'h00..8'h10 -> full=1 and count=16 after 16th; 17th dropped, overflow=1; pulse clrOverflow -> overflow=0; drained order 8'h00..8'h0F.
REQ-037 SHALL be verified by wrap and simultaneous events: 40 bytes streamed with writes coinciding with pops -> count unchanged on those clocks; output order equals input order across pointer wrap.
REQ-038 SHALL be verified by timeout: txBusy held 0 permanently, 3 bytes queued -> each byte gets one transmit pulse, spaced by BUSY_TIMEOUT+2 clocks.
REQ-039 SHALL be verified by reset mid-operation: assert reset while in WAIT_DONE with 5 bytes queued -> outputs match the reset values immediately (before the next clock edge); no transmit after release until a new write.

Source files
------------

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter through a start/busy handshake.
// Ports: clock/reset (async, active-high); wrData/wrEn enqueue;
//   clrOverflow clears the sticky drop flag; txBusy from the transmitter;
//   dataIn/transmit to the transmitter; full/empty/count/overflow status.
module uart_tx_queue #(
    parameter int DEPTH        = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            wrData,
    input  logic                  wrEn,
    input  logic                  clrOverflow,
    input  logic                  txBusy,
    output logic [7:0]            dataIn,
    output logic                  transmit,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [TW-1:0]         timer;
    logic [CW-1:0]         cnt_nx;
    logic                  hold;
    logic                  push;
    logic                  pop;
    logic                  drop;

    // hold masks the first edge after reset release: no write, no pop
    assign push = wrEn && !full && !hold;
    assign drop = wrEn && full && !hold;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        transmit = 1'b0;
        unique case (state)
            IDLE: begin
                if (!hold && !empty && !txBusy) begin
                    pop      = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                transmit = 1'b1;
                state_nx = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // a transmitter that never answers still releases the queue
                if (txBusy) begin
                    state_nx = WAIT_DONE;
                end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
                    state_nx = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!txBusy) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_nx = count;
        if (push && !pop) begin
            cnt_nx = count + CW'(1);
        end else if (pop && !push) begin
            cnt_nx = count - CW'(1);
        end
    end

    // storage is deliberately not reset
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr] <= wrData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold     <= 1'b1;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            dataIn   <= 8'h00;
            timer    <= '0;
        end else begin
            hold  <= 1'b0;
            count <= cnt_nx;
            empty <= (cnt_nx == '0);
            full  <= (cnt_nx == CW'(DEPTH));
            if (push) begin
                wptr <= wptr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rptr   <= rptr + ADDR_WIDTH'(1);
                dataIn <= mem[rptr];
            end
            // a drop in the same clock as a clear leaves the flag set
            if (drop) begin
                overflow <= 1'b1;
            end else if (clrOverflow) begin
                overflow <= 1'b0;
            end
            if (state == WAIT_BUSY) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end
        end
    end

endmodule
